if_id_fetch_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register of the pipelined RV32I core; sits directly upstream of the control unit and feeds it the 32-bit instruction word.
- Owns the PC and a req/ack handshake to instruction memory.
- Inserts NOP bubbles for the control unit's load-use stall signal and for taken branches/jumps, and discards stale memory responses after a redirect.

---
 rtl/if_id_fetch_stage.sv | 180 ++++++++++++++++++
 tb/tb_if_id_fetch_stage.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_fetch_stage.sv
// IF stage and IF/ID register: PC, imem req/ack fetch, one-entry skid,
// load-use/redirect bubbles, stale-response drain. Ports: imem_*, stall_sig, redirect_*, IF/ID outs.
module if_id_fetch_stage #(
  parameter logic [31:0] RESET_PC          = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR         = 32'h0000_0013,
  parameter int unsigned LOAD_STALL_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall_sig,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic [31:0] pc4_out,
  output logic        instr_valid
);

  typedef enum logic [1:0] {
    FETCH,
    STALL,
    DRAIN
  } state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
  } if_id_t;

  localparam logic [1:0] STALL_N = 2'(LOAD_STALL_CYCLES);

  state_t      r_state, w_state;
  logic [31:0] r_pc, w_pc;
  logic        r_req, w_req;
  logic [31:0] r_addr, w_addr;
  if_id_t      r_ifid, w_ifid;
  logic        r_skv, w_skv;
  logic [31:0] r_skd, w_skd;
  logic [31:0] r_skp, w_skp;
  logic [1:0]  r_cnt, w_cnt;

  logic        w_ack;
  logic [31:0] w_pc4;
  logic        w_fetch;
  logic        w_skid_fill;

  assign w_ack = r_req & imem_ack;
  assign w_pc4 = r_pc + 32'd4;

  always_comb begin
    w_state     = r_state;
    w_pc        = r_pc;
    w_req       = r_req;
    w_addr      = r_addr;
    w_ifid      = r_ifid;
    w_ifid.instr = NOP_INSTR;
    w_ifid.valid = 1'b0;
    w_skv       = r_skv;
    w_skd       = r_skd;
    w_skp       = r_skp;
    w_cnt       = r_cnt;
    w_fetch     = 1'b0;
    w_skid_fill = 1'b0;
    if (redirect_valid) begin
      w_pc  = redirect_pc;
      w_skv = 1'b0;
      w_cnt = 2'd0;
      // Unacked request must complete at its old address;
      // its response is thrown away in DRAIN.
      if (r_req && !imem_ack) begin
        w_state = DRAIN;
      end else begin
        w_state = FETCH;
        w_req   = 1'b1;
        w_addr  = redirect_pc;
      end
    end else begin
      unique case (r_state)
        DRAIN: begin
          if (w_ack) begin
            w_state = FETCH;
            w_req   = 1'b1;
            w_addr  = r_pc;
          end
        end
        STALL: begin
          if (r_cnt > 2'd1) begin
            w_cnt       = r_cnt - 2'd1;
            w_skid_fill = w_ack;
          end else begin
            w_state = FETCH;
            w_cnt   = 2'd0;
            if (r_skv) begin
              // Skid word replaces a memory access;
              // the next fetch is launched alongside.
              w_ifid.instr = r_skd;
              w_ifid.pc    = r_skp;
              w_ifid.pc4   = r_skp + 32'd4;
              w_ifid.valid = 1'b1;
              w_skv        = 1'b0;
              w_req        = 1'b1;
              w_addr       = r_pc;
            end else begin
              w_fetch = 1'b1;
            end
          end
        end
        default: begin
          if (stall_sig && r_ifid.valid) begin
            w_state     = STALL;
            w_cnt       = STALL_N;
            w_skid_fill = w_ack;
          end else begin
            w_fetch = 1'b1;
          end
        end
      endcase
      if (w_skid_fill) begin
        w_skv = 1'b1;
        w_skd = imem_rdata;
        w_skp = r_pc;
        w_pc  = w_pc4;
        w_req = 1'b0;
      end
      if (w_fetch) begin
        if (w_ack) begin
          w_ifid.instr = imem_rdata;
          w_ifid.pc    = r_pc;
          w_ifid.pc4   = w_pc4;
          w_ifid.valid = 1'b1;
          w_pc         = w_pc4;
          w_req        = 1'b1;
          w_addr       = w_pc4;
        end else if (!r_req) begin
          w_req  = 1'b1;
          w_addr = r_pc;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FETCH;
      r_pc    <= RESET_PC;
      r_req   <= 1'b0;
      r_addr  <= RESET_PC;
      r_ifid  <= '{instr: NOP_INSTR, pc: 32'd0,
                   pc4: 32'd0, valid: 1'b0};
      r_skv   <= 1'b0;
      r_skd   <= 32'd0;
      r_skp   <= 32'd0;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state;
      r_pc    <= w_pc;
      r_req   <= w_req;
      r_addr  <= w_addr;
      r_ifid  <= w_ifid;
      r_skv   <= w_skv;
      r_skd   <= w_skd;
      r_skp   <= w_skp;
      r_cnt   <= w_cnt;
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_addr;
  assign instr_out   = r_ifid.instr;
  assign pc_out      = r_ifid.pc;
  assign pc4_out     = r_ifid.pc4;
  assign instr_valid = r_ifid.valid;

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Randomized self-checking bench for if_id_fetch_stage: program-order
// reference, handshake rules, bubble counts, redirect/reset behaviour.
module tb_if_id_fetch_stage;

  localparam int          LSC = 1;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall_sig;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [31:0] pc4_out;
  logic        instr_valid;
  logic        ack_en;

  if_id_fetch_stage #(
    .RESET_PC(RPC),
    .NOP_INSTR(NOP),
    .LOAD_STALL_CYCLES(LSC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .stall_sig(stall_sig),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .instr_out(instr_out),
    .pc_out(pc_out),
    .pc4_out(pc4_out),
    .instr_valid(instr_valid)
  );

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign imem_ack   = imem_req & ack_en;
  assign imem_rdata = ack_en ? memw(imem_addr) : 32'hDEAD_BEEF;

  always #5 clk = ~clk;

  int n_chk, n_err;
  int mode, cyc, p_redir, p_stall;
  logic [31:0] exp_pc;
  int  bub;
  bit  stall_nr, warm, first_chk;
  bit  pr_req, pr_ack;
  logic [31:0] pr_addr;
  bit  na_chk;
  logic [31:0] na_exp;
  bit  w_stall;
  logic [31:0] w_stall_pc;
  bit  w_redir, w_redir_aen;
  logic [31:0] w_redir_tgt, w_redir_addr;
  bit  w_both;
  logic [31:0] w_both_tgt;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rand_tgt();
    logic [31:0] t;
    if ($urandom_range(0, 7) == 0)
      t = {28'hFFFF_FFF, 2'($urandom_range(0, 3)), 2'b00};
    else
      t = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
    return t;
  endfunction

  task automatic model_reset();
    exp_pc    = RPC;
    bub       = 0;
    stall_nr  = 0;
    warm      = 0;
    pr_req    = 0;
    pr_ack    = 0;
    pr_addr   = '0;
    na_chk    = 1;
    na_exp    = RPC;
    first_chk = 1;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_req"},   32'(imem_req), 0);
    check({tag, "_addr"},  imem_addr, RPC);
    check({tag, "_instr"}, instr_out, NOP);
    check({tag, "_pc"},    pc_out, 0);
    check({tag, "_pc4"},   pc4_out, 0);
    check({tag, "_valid"}, 32'(instr_valid), 0);
  endtask

  task automatic observe();
    bit nr;
    nr = imem_req && (!pr_req || pr_ack);
    if (first_chk) begin
      check("first_req", 32'(imem_req), 1);
      first_chk = 0;
    end
    if (pr_req && !pr_ack) begin
      check("hold_req", 32'(imem_req), 1);
      check("hold_addr", imem_addr, pr_addr);
    end
    if (nr && na_chk) begin
      check("new_addr", imem_addr, na_exp);
      na_chk = 0;
    end
    if (bub > 0) begin
      check("bubble", 32'(instr_valid), 0);
      if (stall_nr) check("stall_noreq", 32'(nr), 0);
      bub--;
      if (bub == 0) stall_nr = 0;
    end else if (mode == 0 && warm) begin
      check("thruput", 32'(instr_valid), 1);
    end
    if (instr_valid) begin
      check("pc", pc_out, exp_pc);
      check("instr", instr_out, memw(exp_pc));
      check("pc4", pc4_out, pc_out + 32'd4);
      exp_pc = exp_pc + 32'd4;
      if (mode == 0) warm = 1;
    end else begin
      check("nop", instr_out, NOP);
    end
  endtask

  task automatic drive();
    bit rd, st;
    logic [31:0] tg;
    cyc++;
    unique case (mode)
      0:       ack_en = 1'b1;
      1:       ack_en = (cyc % 3 == 0);
      default: ack_en = 1'($urandom_range(0, 1));
    endcase
    rd = ($urandom_range(0, 99) < p_redir);
    st = ($urandom_range(0, 99) < p_stall);
    tg = rand_tgt();
    if (w_redir && imem_req && !ack_en &&
        (!w_redir_aen || imem_addr == w_redir_addr)) begin
      rd = 1;
      tg = w_redir_tgt;
      w_redir = 0;
    end
    if (w_stall && instr_valid && pc_out == w_stall_pc) begin
      st = 1;
      rd = 0;
      w_stall = 0;
    end
    if (w_both && instr_valid) begin
      rd = 1;
      st = 1;
      tg = w_both_tgt;
      w_both = 0;
    end
    redirect_valid = rd;
    redirect_pc    = tg;
    stall_sig      = st;
    pr_req  = imem_req;
    pr_ack  = imem_req & ack_en;
    pr_addr = imem_addr;
    if (rd) begin
      exp_pc   = tg;
      bub      = 1;
      stall_nr = 0;
      na_chk   = 1;
      na_exp   = tg;
    end else if (st && instr_valid && bub == 0) begin
      bub      = LSC;
      stall_nr = 1;
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      observe();
      drive();
    end
  endtask

  task automatic reset_pulse();
    redirect_valid = 0;
    stall_sig      = 0;
    ack_en         = 0;
    #1 rst_n = 0;
    #1 reset_checks("rst_async");
    @(posedge clk);
    @(negedge clk);
    reset_checks("rst_hold");
    rst_n = 1;
    model_reset();
  endtask

  initial begin
    clk = 0;
    rst_n = 0;
    ack_en = 0;
    stall_sig = 0;
    redirect_valid = 0;
    redirect_pc = '0;
    n_chk = 0;
    n_err = 0;
    cyc = 0;
    mode = 0;
    p_redir = 0;
    p_stall = 0;
    w_stall = 0;
    w_redir = 0;
    w_redir_aen = 0;
    w_both = 0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_checks("rst_init");
    rst_n = 1;
    model_reset();

    // zero-wait stream, load-use stall with lw at 0xC
    w_stall = 1;
    w_stall_pc = 32'hC;
    run(20);
    check("stall_fired", 32'(w_stall), 0);

    // slow memory, redirect to 0x100 while 0x20 pending
    reset_pulse();
    mode = 1;
    w_redir = 1;
    w_redir_tgt = 32'h100;
    w_redir_aen = 1;
    w_redir_addr = 32'h20;
    run(60);
    check("drain_fired", 32'(w_redir), 0);

    // redirect + stall + ack on one edge
    mode = 0;
    warm = 0;
    w_both = 1;
    w_both_tgt = 32'h200;
    run(12);
    check("both_fired", 32'(w_both), 0);

    // reset while draining
    mode = 1;
    w_redir = 1;
    w_redir_tgt = 32'h300;
    w_redir_aen = 0;
    for (int i = 0; i < 20 && w_redir; i++) run(1);
    check("drain2_fired", 32'(w_redir), 0);
    @(negedge clk);
    observe();
    reset_pulse();

    // reset while stalled
    mode = 0;
    w_stall = 1;
    w_stall_pc = 32'h8;
    for (int i = 0; i < 20 && w_stall; i++) run(1);
    check("stall2_fired", 32'(w_stall), 0);
    @(negedge clk);
    observe();
    reset_pulse();
    run(10);

    // randomized traffic in every memory mode
    p_redir = 4;
    p_stall = 10;
    for (int m = 0; m < 3; m++) begin
      mode = m;
      warm = 0;
      run(400);
    end
    mode = 2;
    p_redir = 12;
    p_stall = 20;
    run(300);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
